// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes engine: substitutes LANES bytes of a 128-bit
// state per cycle using time-shared inverse S-box tables.

module aes_inv_sbox (
   input  logic [7:0] x,
   output logic [7:0] y
);

   // Row r of the table holds InvS(16*r) .. InvS(16*r+15), most significant byte first.
   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   assign y = INV_SBOX[x];

endmodule

module inv_sub_bytes_seq #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   localparam int K   = 16 / LANES;
   localparam int CW  = (K > 1) ? $clog2(K) : 1;
   localparam int LSH = $clog2(LANES);

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
   end

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [7:0]    work [16];
   logic [3:0]    base;
   logic [3:0]    lane_idx [LANES];
   logic [7:0]    sbox_in  [LANES];
   logic [7:0]    sbox_out [LANES];

   // First byte of the current pass; higher bits shifted out are always zero for legal counts.
   assign base = 4'(cnt) << LSH;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_idx[l] = base + 4'(l);
      assign sbox_in[l]  = work[lane_idx[l]];
      aes_inv_sbox u_sbox (
         .x (sbox_in[l]),
         .y (sbox_out[l])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b1;
         for (int b = 0; b < 16; b++) work[b] <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  for (int b = 0; b < 16; b++) work[b] <= in_state[127-8*b -: 8];
                  cnt      <= '0;
                  state    <= BUSY;
                  busy     <= 1'b1;
                  in_ready <= 1'b0;
               end
            end
            BUSY: begin
               for (int l = 0; l < LANES; l++) work[lane_idx[l]] <= sbox_out[l];
               cnt <= cnt + 1'b1;
               if (cnt == CW'(K - 1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      out_state = '0;
      for (int b = 0; b < 16; b++) out_state[127-8*b -: 8] = work[b];
   end

endmodule

// File: doc/inv_sub_bytes_seq.md
# inv_sub_bytes_seq

Sequential InvSubBytes engine for the AES decipher datapath. It applies the inverse S-box to all 16 bytes of a 128-bit state, LANES bytes per cycle. A small number of inverse S-box tables is time-shared, which reduces area compared with 16 parallel lookups. It sits between InvShiftRows and AddRoundKey in the decipher round loop and uses valid/ready handshakes on both sides.

## Interface
- LANES, default 4: bytes substituted per cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  upstream presents a state on in_state.
- in_ready  output  1  block can accept a state; equals (state == IDLE).
- in_state  input  128  state to invert; byte 0 = [127:120], byte 15 = [7:0].
- out_valid  output  1  out_state holds a complete InvSubBytes result.
- out_ready  input  1  downstream accepts the result.
- out_state  output  128  work register contents; meaningful only while out_valid = 1.
- busy  output  1  high in BUSY and DONE.

## Operation
- Contains LANES instances of a new combinational 256-entry inverse S-box, aes_inv_sbox, with 8-bit in and 8-bit out. It is the exact inverse of the forward S-box: InvS(0x63)=0x00, InvS(0x00)=0x52, InvS(0x01)=0x09, InvS(0x16)=0xFF, InvS(0x7A)=0xBD.
- K = 16/LANES. A pass counter cnt counts 0..K-1 and is at least 1 bit wide.
- FSM states:
  - IDLE: in_ready = 1. If in_valid, capture in_state into the work register, clear cnt, and go to BUSY.
  - BUSY: each cycle, replace bytes cnt·LANES .. cnt·LANES+LANES-1 of the work register in place with their InvS values, then increment cnt. On the cycle where cnt = K-1, go to DONE.
  - DONE: out_valid = 1 and the work register is frozen. If out_ready, go to IDLE. Otherwise hold indefinitely with out_state stable.
- No overlap: in_ready = 0 in BUSY and DONE, and in_valid is ignored there.
- Bytes already substituted are never revisited. Each byte is looked up exactly once per block.
- Reset (rst_n low), including mid-BUSY or mid-DONE:
  - The block is forced to IDLE immediately and any in-flight block is discarded.
  - Reset values: work register = 0, cnt = 0, out_valid = 0, busy = 0, in_ready = 1 (follows IDLE), out_state = 0.
  - Upstream must hold in_valid low while rst_n is low.

## Timing
- Accept at rising edge N (in_valid & in_ready). Bytes are substituted at edges N+1 .. N+K.
- out_valid rises after edge N+K. Latency is K cycles: 4 for LANES = 4, 16 for LANES = 1, 1 for LANES = 16.
- Output handshake completes at the first edge M ≥ N+K+1 with out_ready = 1. out_valid and busy fall after M, and in_ready rises after M.
- Best-case throughput is one block per K+2 cycles (out_ready tied high).
- out_valid, busy and out_state change only on clock edges or on asynchronous reset assertion.
- out_state while out_valid = 0 shows the partially substituted work register. Benches check it only when out_valid = 1.

## Test plan
- Reset/idle:
  - Drive rst_n low, then release.
  - Required: out_valid = 0, busy = 0, in_ready = 1, out_state = 0.
  - Hold in_valid = 0 for 10 cycles; required: no change.
- FIPS-197 vector:
  - LANES = 4, in_state = 7a9f102789d5f50b2beffd9f3dca4ea7, out_ready = 1.
  - Required: out_valid rises exactly 4 cycles after accept, with out_state = bd6e7c3df2b5779e0b61216e8b10b689.
- Constant state:
  - in_state = 63 repeated 16 times; required: out_state = 0.
  - in_state = 0; required: out_state = 52 repeated 16 times.
  - Repeat for LANES = 1, 2, 8, 16 and check latency of 16, 8, 2, 1 cycles respectively.
- Backpressure:
  - Hold out_ready = 0 for 20 cycles after out_valid.
  - Required: out_state stable, in_ready = 0, and a second in_valid is ignored.
  - Then pulse out_ready for one cycle. Required: in_ready = 1 on the next cycle, and the second block is accepted and correct.
- Reset mid-operation:
  - Assert rst_n low two cycles into BUSY.
  - Required: out_valid never rises and busy = 0 immediately.
  - After release, a fresh block processes correctly.
- Round trip:
  - Apply 1000 random states x through the existing forward SubBytes model, then through this block with random out_ready stalls.
  - Required: every result equals x, delivered in order and with none dropped.
